// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle control FSM for the 16-bit MIPS machine.
// It sequences FETCH/DECODE/EXEC/MEM/WB, latches the instruction register,
// drives next_pc/pc_write, and bounds every memory wait with a timeout that
// faults the machine into HALT.
module pc_sequencer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] pc,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  input  logic        alu_zero,
  output logic [15:0] next_pc,
  output logic        pc_write,
  output logic [15:0] ir,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_sel,
  output logic        alu_src_imm,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic [2:0]  state,
  output logic        halted,
  output logic        fault
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_RTYPE = 4'd0;
  localparam logic [3:0] OP_ADDI  = 4'd1;
  localparam logic [3:0] OP_LW    = 4'd2;
  localparam logic [3:0] OP_SW    = 4'd3;
  localparam logic [3:0] OP_BEQ   = 4'd4;
  localparam logic [3:0] OP_BNE   = 4'd5;
  localparam logic [3:0] OP_J     = 4'd6;
  localparam logic [3:0] OP_HALT  = 4'd15;

  // The wait that would bring the counter up to TIMEOUT is the faulting one.
  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] ir_q;
  logic [7:0]  wait_cnt;
  logic        fault_q;
  logic        timeout;
  logic        pc_write_raw;
  logic [3:0]  opcode;
  logic [15:0] pc_plus2;
  logic [15:0] branch_target;
  logic [15:0] jump_target;

  assign opcode        = ir_q[15:12];
  assign pc_plus2      = pc + 16'd2;
  // Offset counts instructions, so it is sign-extended and scaled by 2.
  assign branch_target = pc + {{7{ir_q[7]}}, ir_q[7:0], 1'b0};
  assign jump_target   = {pc[15:13], ir_q[11:0], 1'b0};

  // Next-state and control decode from the current state and instruction.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned
    // (that would infer a latch).
    state_d      = state_q;
    next_pc      = pc_plus2;
    pc_write_raw = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_sel      = 1'b0;
    alu_src_imm  = 1'b0;
    mem_to_reg   = 1'b0;
    reg_write    = 1'b0;
    timeout      = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          pc_write_raw = 1'b1;
          state_d      = S_DECODE;
        end else if (wait_cnt == WAIT_LIMIT) begin
          timeout = 1'b1;
          state_d = S_HALT;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_J: begin
            pc_write_raw = 1'b1;
            next_pc      = jump_target;
            state_d      = S_FETCH;
          end
          OP_HALT: state_d = S_HALT;
          OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE: state_d = S_EXEC;
          default: state_d = S_FETCH;
        endcase
      end
      S_EXEC: begin
        alu_src_imm = (opcode == OP_ADDI) || (opcode == OP_LW) || (opcode == OP_SW);
        case (opcode)
          OP_BEQ, OP_BNE: begin
            if ((opcode == OP_BEQ) == alu_zero) begin
              pc_write_raw = 1'b1;
              next_pc      = branch_target;
            end
            state_d = S_FETCH;
          end
          OP_LW, OP_SW: state_d = S_MEM;
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        mem_sel   = 1'b1;
        mem_read  = (opcode == OP_LW);
        mem_write = (opcode == OP_SW);
        if (mem_ready) begin
          state_d = (opcode == OP_LW) ? S_WB : S_FETCH;
        end else if (wait_cnt == WAIT_LIMIT) begin
          timeout = 1'b1;
          state_d = S_HALT;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (opcode == OP_LW);
        state_d    = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // PC loads are held off while reset is asserted.
  assign pc_write = pc_write_raw & ~reset;
  assign ir       = ir_q;
  assign state    = state_q;
  assign halted   = (state_q == S_HALT);
  assign fault    = fault_q;

  // State register, instruction latch, sticky fault flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      ir_q    <= 16'h0000;
      fault_q <= 1'b0;
    end else begin
      // NOTE: sequential state is updated with non-blocking assignments so all
      // registers see pre-edge values regardless of statement order.
      state_q <= state_d;
      if (state_q == S_FETCH && mem_ready) ir_q <= mem_rdata;
      if (timeout) fault_q <= 1'b1;
    end
  end

  // Memory wait counter: counts stalled FETCH/MEM cycles, clears on a state change.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt <= 8'd0;
    end else if (state_d != state_q) begin
      wait_cnt <= 8'd0;
    end else if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer: hand-computed expectations for each
// instruction class, memory waits, timeout, address wrap and mid-op reset.
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] pc;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        alu_zero;
  logic [15:0] next_pc;
  logic        pc_write;
  logic [15:0] ir;
  logic        mem_read;
  logic        mem_write;
  logic        mem_sel;
  logic        alu_src_imm;
  logic        mem_to_reg;
  logic        reg_write;
  logic [2:0]  state;
  logic        halted;
  logic        fault;

  int checks   = 0;
  int failures = 0;

  pc_sequencer #(.TIMEOUT(15)) dut (
    .clock       (clock),
    .reset       (reset),
    .pc          (pc),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .alu_zero    (alu_zero),
    .next_pc     (next_pc),
    .pc_write    (pc_write),
    .ir          (ir),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_sel     (mem_sel),
    .alu_src_imm (alu_src_imm),
    .mem_to_reg  (mem_to_reg),
    .reg_write   (reg_write),
    .state       (state),
    .halted      (halted),
    .fault       (fault)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // Advance one clock, then let inputs be changed well away from the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Apply a short asynchronous reset pulse between edges.
  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
  endtask

  // Complete a zero-wait fetch of word w at address a; leaves the FSM in DECODE
  // with pc advanced to a+2 as the PC register would.
  task automatic fetch(input logic [15:0] a, input logic [15:0] w);
    pc = a; mem_rdata = w; mem_ready = 1'b1;
    #1;
    check("fetch_state", 16'(state), 16'd0);
    check("fetch_pc_write", 16'(pc_write), 16'd1);
    check("fetch_next_pc", next_pc, a + 16'd2);
    tick();
    pc = a + 16'd2;
    #1;
    check("decode_ir", ir, w);
  endtask

  initial begin
    reset = 1'b1; pc = 16'h1234; mem_rdata = 16'h0000; mem_ready = 1'b1; alu_zero = 1'b0;
    #3;
    // Outputs during reset: FETCH requests only, no PC load even with mem_ready.
    check("rst_state", 16'(state), 16'd0);
    check("rst_ir", ir, 16'h0000);
    check("rst_mem_read", 16'(mem_read), 16'd1);
    check("rst_mem_sel", 16'(mem_sel), 16'd0);
    check("rst_pc_write", 16'(pc_write), 16'd0);
    check("rst_next_pc", next_pc, 16'h1236);
    check("rst_halted", 16'(halted), 16'd0);
    check("rst_fault", 16'(fault), 16'd0);
    tick();
    reset = 1'b0;
    #1;

    // R-type at 0x0000: F, D, E, WB, back to FETCH.
    fetch(16'h0000, 16'h0123);
    check("r_decode_state", 16'(state), 16'd1);
    tick(); #1;
    check("r_exec_state", 16'(state), 16'd2);
    check("r_exec_imm", 16'(alu_src_imm), 16'd0);
    check("r_exec_pc_write", 16'(pc_write), 16'd0);
    check("r_exec_next_pc", next_pc, 16'h0004);
    tick(); #1;
    check("r_wb_state", 16'(state), 16'd4);
    check("r_wb_reg_write", 16'(reg_write), 16'd1);
    check("r_wb_mem_to_reg", 16'(mem_to_reg), 16'd0);
    tick(); #1;
    check("r_back_fetch", 16'(state), 16'd0);

    // Taken BEQ backward from 0x0010: target 0x0012 - 4 = 0x000E.
    fetch(16'h0010, 16'h40FE);
    tick(); alu_zero = 1'b1; #1;
    check("beq_exec_state", 16'(state), 16'd2);
    check("beq_pc_write", 16'(pc_write), 16'd1);
    check("beq_next_pc", next_pc, 16'h000E);
    tick(); #1;
    check("beq_back_fetch", 16'(state), 16'd0);

    // BNE with alu_zero=1: not taken.
    fetch(16'h0010, 16'h50FE);
    tick(); alu_zero = 1'b1; #1;
    check("bne_pc_write", 16'(pc_write), 16'd0);
    check("bne_next_pc", next_pc, 16'h0014);
    tick(); alu_zero = 1'b0; #1;
    check("bne_back_fetch", 16'(state), 16'd0);

    // Jump: {111, 0xABC, 0} = 0xF578.
    fetch(16'hE000, 16'h6ABC);
    check("j_pc_write", 16'(pc_write), 16'd1);
    check("j_next_pc", next_pc, 16'hF578);
    tick(); #1;
    check("j_back_fetch", 16'(state), 16'd0);

    // LW with 3 wait cycles in MEM.
    fetch(16'h0100, 16'h2105);
    tick(); #1;
    check("lw_exec_imm", 16'(alu_src_imm), 16'd1);
    tick();
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1;
      check("lw_mem_state", 16'(state), 16'd3);
      check("lw_mem_read", 16'(mem_read), 16'd1);
      check("lw_mem_sel", 16'(mem_sel), 16'd1);
      check("lw_mem_write", 16'(mem_write), 16'd0);
      tick();
    end
    #1;
    check("lw_wb_state", 16'(state), 16'd4);
    check("lw_wb_reg_write", 16'(reg_write), 16'd1);
    check("lw_wb_mem_to_reg", 16'(mem_to_reg), 16'd1);
    tick(); #1;
    check("lw_back_fetch", 16'(state), 16'd0);

    // Fetch at 0xFFFE wraps next_pc to 0x0000; NOP returns to FETCH from DECODE.
    fetch(16'hFFFE, 16'h7000);
    tick(); #1;
    check("nop_back_fetch", 16'(state), 16'd0);

    // SW, reset asserted mid-MEM: mem_write drops immediately.
    fetch(16'h0200, 16'h3105);
    tick(); tick();
    mem_ready = 1'b0; #1;
    check("sw_mem_state", 16'(state), 16'd3);
    check("sw_mem_write", 16'(mem_write), 16'd1);
    reset = 1'b1; #1;
    check("sw_rst_mem_write", 16'(mem_write), 16'd0);
    check("sw_rst_state", 16'(state), 16'd0);
    tick();
    reset = 1'b0; #1;

    // Timeout in FETCH: 15 stalled cycles fault into HALT.
    mem_ready = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    #1;
    check("to_pre_state", 16'(state), 16'd0);
    check("to_pre_fault", 16'(fault), 16'd0);
    tick(); #1;
    check("to_state", 16'(state), 16'd5);
    check("to_halted", 16'(halted), 16'd1);
    check("to_fault", 16'(fault), 16'd1);
    check("to_mem_read", 16'(mem_read), 16'd0);
    mem_ready = 1'b1; tick(); #1;
    check("to_stays_halt", 16'(state), 16'd5);
    do_reset();
    check("to_rst_halted", 16'(halted), 16'd0);
    check("to_rst_fault", 16'(fault), 16'd0);

    // mem_ready arriving on the 15th cycle wins over the timeout.
    mem_ready = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    mem_rdata = 16'h7000; mem_ready = 1'b1; #1;
    check("late_pc_write", 16'(pc_write), 16'd1);
    tick(); #1;
    check("late_state", 16'(state), 16'd1);
    check("late_fault", 16'(fault), 16'd0);
    tick(); #1;

    // HALT opcode: clean halt without fault.
    fetch(16'h0300, 16'hF000);
    tick(); #1;
    check("halt_state", 16'(state), 16'd5);
    check("halt_halted", 16'(halted), 16'd1);
    check("halt_fault", 16'(fault), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
